pst_pattern_sequencer: RTL

Stimulus-side counterpart of pst_brain_v1. It drives the four input currents cur0..cur3 with pattern A or pattern B on a gamma-cycle schedule, and reads back pred_err and winner. It measures how many gamma cycles each pattern switch takes to converge. It sits between the brain and the SoC/bench control, replacing hand-written switching stimulus with a synthesizable sequencer.

---
 rtl/pst_seq_pkg.sv | 51 +++++
 rtl/pst_pattern_sequencer_if.sv | 42 ++++
 rtl/pst_gamma_timer.sv | 33 +++
 rtl/pst_pattern_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pst_seq_pkg.sv
// Shared types and constants for the pattern sequencer: FSM states, winner codes,
// pattern selects and the packed current-drive bundle.
package pst_seq_pkg;

    localparam int unsigned CUR_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SW_W  = 4;
    localparam int unsigned WIN_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        OBSERVE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [WIN_W-1:0] WIN_AB = 3'd0;
    localparam logic [WIN_W-1:0] WIN_CD = 3'd5;

    localparam logic PAT_A = 1'b0;
    localparam logic PAT_B = 1'b1;

    typedef struct packed {
        logic [CUR_W-1:0] c0;
        logic [CUR_W-1:0] c1;
        logic [CUR_W-1:0] c2;
        logic [CUR_W-1:0] c3;
    } cur_t;

    // Pattern B mirrors pattern A: the strong pair moves from cur0/cur1 to cur2/cur3.
    function automatic cur_t pat_drive(input logic             pat,
                                       input logic [CUR_W-1:0] hi0,
                                       input logic [CUR_W-1:0] hi1,
                                       input logic [CUR_W-1:0] lo0,
                                       input logic [CUR_W-1:0] lo1);
        cur_t d;
        if (pat == PAT_A) begin
            d.c0 = hi0;
            d.c1 = hi1;
            d.c2 = lo0;
            d.c3 = lo1;
        end else begin
            d.c0 = lo0;
            d.c1 = lo1;
            d.c2 = hi0;
            d.c3 = hi1;
        end
        return d;
    endfunction

endpackage

// File: rtl/pst_pattern_sequencer_if.sv
// Control/stimulus bundle between the pattern sequencer and its controller/brain.
// Optional winner_err member present when PST_SEQ_WINNER_CHECK_EN is defined.
interface pst_pattern_sequencer_if;

    logic       start;
    logic       abort;
    logic [7:0] pred_err;
    logic [2:0] winner;
    logic [7:0] cur0;
    logic [7:0] cur1;
    logic [7:0] cur2;
    logic [7:0] cur3;
    logic       busy;
    logic       gamma_tick;
    logic [3:0] switch_idx;
    logic       cur_pat;
    logic       conv_valid;
    logic [7:0] conv_cyc;
    logic       done;
`ifdef PST_SEQ_WINNER_CHECK_EN
    logic       winner_err;
`endif

    modport slave (
        input  start, abort, pred_err, winner,
        output cur0, cur1, cur2, cur3, busy, gamma_tick, switch_idx,
               cur_pat, conv_valid, conv_cyc, done
`ifdef PST_SEQ_WINNER_CHECK_EN
        , output winner_err
`endif
    );

    modport master (
        output start, abort, pred_err, winner,
        input  cur0, cur1, cur2, cur3, busy, gamma_tick, switch_idx,
               cur_pat, conv_valid, conv_cyc, done
`ifdef PST_SEQ_WINNER_CHECK_EN
        , input winner_err
`endif
    );

endinterface

// File: rtl/pst_gamma_timer.sv
// Clock-in-gamma-cycle counter; o_tick is a registered pulse on the last clock of
// each gamma cycle. i_clr holds the counter at 0.
module pst_gamma_timer #(
    parameter int unsigned GAMMA_LEN = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(GAMMA_LEN);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Tick is registered one clock ahead so it lines up with r_cnt == GAMMA_LEN-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CW'(GAMMA_LEN - 1)) ? '0 : r_cnt + CW'(1);
            r_tick <= (r_cnt == CW'(GAMMA_LEN - 2));
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/pst_pattern_sequencer.sv
// Drives pattern A/B currents into the brain on a gamma-cycle schedule and measures
// convergence latency per switch. Optional winner check: PST_SEQ_WINNER_CHECK_EN.
module pst_pattern_sequencer
    import pst_seq_pkg::*;
#(
    parameter int unsigned GAMMA_LEN    = 256,
    parameter int unsigned SETTLE_CYC   = 15,
    parameter int unsigned OBSERVE_CYC  = 15,
    parameter int unsigned NUM_SWITCHES = 2,
    parameter logic [7:0]  ERR_TOL      = 8'd3,
    parameter logic [7:0]  CUR_HI0      = 8'd200,
    parameter logic [7:0]  CUR_HI1      = 8'd180,
    parameter logic [7:0]  CUR_LO0      = 8'd5,
    parameter logic [7:0]  CUR_LO1      = 8'd8
) (
    input logic                   clk,
    input logic                   rst,
    pst_pattern_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] OBSERVE_N = CNT_W'(OBSERVE_CYC);
    localparam logic [SW_W-1:0]  LAST_SW   = SW_W'(NUM_SWITCHES - 1);

    state_t           r_state,      w_state_nxt;
    logic             r_pat,        w_pat_nxt;
    logic [SW_W-1:0]  r_sw,         w_sw_nxt;
    logic [CNT_W-1:0] r_gcnt,       w_gcnt_nxt;
    logic             r_hit,        w_hit_nxt;
    logic [CNT_W-1:0] r_hit_cyc,    w_hit_cyc_nxt;
    logic [CNT_W-1:0] r_conv_cyc,   w_conv_cyc_nxt;
    logic             r_conv_valid, w_conv_valid_nxt;
    logic             r_done,       w_done_nxt;
    logic             r_busy,       w_busy_nxt;
    cur_t             r_cur,        w_cur_nxt;

    logic             w_tick;
    logic             w_timer_clr;
    logic [CNT_W-1:0] w_k;

    // Timer runs only while a run is active and restarts from 0 on every entry.
    assign w_timer_clr = (r_state == IDLE) || (w_state_nxt == IDLE);

    pst_gamma_timer #(
        .GAMMA_LEN(GAMMA_LEN)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_timer_clr),
        .o_tick (w_tick)
    );

    // Gamma count after this tick, saturating at 255.
    assign w_k = (r_gcnt == 8'hFF) ? r_gcnt : r_gcnt + 8'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_pat_nxt        = r_pat;
        w_sw_nxt         = r_sw;
        w_gcnt_nxt       = r_gcnt;
        w_hit_nxt        = r_hit;
        w_hit_cyc_nxt    = r_hit_cyc;
        w_conv_cyc_nxt   = r_conv_cyc;
        w_conv_valid_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_cur_nxt        = r_cur;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SETTLE;
                    w_pat_nxt   = PAT_A;
                    w_cur_nxt   = pat_drive(PAT_A, CUR_HI0, CUR_HI1, CUR_LO0, CUR_LO1);
                    w_sw_nxt    = '0;
                    w_gcnt_nxt  = '0;
                    w_hit_nxt   = 1'b0;
                end
            end

            SETTLE: begin
                if (w_tick) begin
                    if (w_k == SETTLE_N) begin
                        w_state_nxt = OBSERVE;
                        w_pat_nxt   = ~r_pat;
                        w_cur_nxt   = pat_drive(~r_pat, CUR_HI0, CUR_HI1, CUR_LO0, CUR_LO1);
                        w_gcnt_nxt  = '0;
                        w_hit_nxt   = 1'b0;
                    end else begin
                        w_gcnt_nxt  = w_k;
                    end
                end
            end

            OBSERVE: begin
                if (w_tick) begin
                    w_gcnt_nxt = w_k;
                    // k == 1 still reflects the pre-switch state, so it never counts.
                    if (!r_hit && (w_k >= 8'd2) && (bus.pred_err <= ERR_TOL)) begin
                        w_hit_nxt     = 1'b1;
                        w_hit_cyc_nxt = w_k;
                    end
                    if (w_k == OBSERVE_N) begin
                        w_conv_valid_nxt = 1'b1;
                        w_conv_cyc_nxt   = w_hit_nxt ? w_hit_cyc_nxt : OBSERVE_N;
                        if (r_sw == LAST_SW) begin
                            w_state_nxt = FINISH;
                            w_done_nxt  = 1'b1;
                            w_cur_nxt   = '0;
                        end else begin
                            w_sw_nxt   = r_sw + 4'd1;
                            w_pat_nxt  = ~r_pat;
                            w_cur_nxt  = pat_drive(~r_pat, CUR_HI0, CUR_HI1, CUR_LO0, CUR_LO1);
                            w_gcnt_nxt = '0;
                            w_hit_nxt  = 1'b0;
                        end
                    end
                end
            end

            FINISH: begin
                w_state_nxt = IDLE;
                w_sw_nxt    = '0;
                w_cur_nxt   = '0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses the result pulses.
        if (bus.abort && (r_state != IDLE)) begin
            w_state_nxt      = IDLE;
            w_pat_nxt        = PAT_A;
            w_sw_nxt         = '0;
            w_gcnt_nxt       = '0;
            w_hit_nxt        = 1'b0;
            w_hit_cyc_nxt    = r_hit_cyc;
            w_conv_cyc_nxt   = r_conv_cyc;
            w_conv_valid_nxt = 1'b0;
            w_done_nxt       = 1'b0;
            w_cur_nxt        = '0;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pat        <= PAT_A;
            r_sw         <= '0;
            r_gcnt       <= '0;
            r_hit        <= 1'b0;
            r_hit_cyc    <= '0;
            r_conv_cyc   <= '0;
            r_conv_valid <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_cur        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pat        <= w_pat_nxt;
            r_sw         <= w_sw_nxt;
            r_gcnt       <= w_gcnt_nxt;
            r_hit        <= w_hit_nxt;
            r_hit_cyc    <= w_hit_cyc_nxt;
            r_conv_cyc   <= w_conv_cyc_nxt;
            r_conv_valid <= w_conv_valid_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
            r_cur        <= w_cur_nxt;
        end
    end

`ifdef PST_SEQ_WINNER_CHECK_EN
    logic w_win_end;
    logic w_start_acc;
    logic r_werr, w_werr_nxt;

    assign w_win_end   = (r_state == OBSERVE) && w_tick && (w_k == OBSERVE_N) && !bus.abort;
    assign w_start_acc = (r_state == IDLE) && bus.start;

    // Sticky winner mismatch, checked against the pattern of the window just ending.
    always_comb begin
        w_werr_nxt = r_werr;
        if (w_start_acc) begin
            w_werr_nxt = 1'b0;
        end else if (w_win_end && (bus.winner != ((r_pat == PAT_B) ? WIN_CD : WIN_AB))) begin
            w_werr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_werr <= 1'b0;
        end else begin
            r_werr <= w_werr_nxt;
        end
    end

    assign bus.winner_err = r_werr;
`endif

    assign bus.cur0       = r_cur.c0;
    assign bus.cur1       = r_cur.c1;
    assign bus.cur2       = r_cur.c2;
    assign bus.cur3       = r_cur.c3;
    assign bus.busy       = r_busy;
    assign bus.gamma_tick = w_tick;
    assign bus.switch_idx = r_sw;
    assign bus.cur_pat    = r_pat;
    assign bus.conv_valid = r_conv_valid;
    assign bus.conv_cyc   = r_conv_cyc;
    assign bus.done       = r_done;

endmodule
